pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register; generalises the fixed-field EX/MEM latch into a width-configurable stage with a valid/ready handshake, priority flush/stall, an optional skid buffer, and a saturating backpressure counter. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The surrounding stage logic packs its control and data fields into a single payload vector.

---
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Width-configurable CPU pipeline stage register with a valid/ready
// handshake. It sits between two pipeline stages, such as IF/ID, ID/EX,
// EX/MEM or MEM/WB. The neighbouring stage logic packs its control and
// data fields into one payload vector.
//
// Per-cycle priority: rst > flush > stall > normal.
//   - flush drops every stored beat. Any beat offered in the same cycle
//     is discarded.
//   - stall freezes the stored beats, masks out_valid and blocks in_ready.
//
// Optional feature (macro PIPE_SKID_EN)
//   When the macro is defined, a second skid register is added.
//   in_ready then depends only on stall and skid occupancy, with no
//   combinational path from out_ready. Without the macro, the stage
//   holds at most one beat.
//
// Parameters
//   DATA_W        payload width (1..1024)
//   ZERO_ON_FLUSH 1: flush also zeroes stored payload; 0: only valids drop
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      discard all stage contents this cycle
//   stall      hazard-unit hold
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts
//   out_data   downstream payload (registered)
//   occupancy  stored beats, 0..2
//   bp_cnt     saturating count of backpressure/stall cycles
module pipe_stage_reg #(
    parameter int DATA_W        = 128,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [31:0]       bp_cnt
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic              main_vld_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic [31:0]       bp_cnt_r;
    logic              accept;
    logic              deliver;
    logic              bp_event;

`ifdef PIPE_SKID_EN
    logic              skid_vld_p0;
    logic [DATA_W-1:0] skid_data_p0;
`endif

    // A stalled stage presents nothing downstream.
    // The stored payload stays visible on out_data.
    assign out_valid = main_vld_p0 & ~stall;
    assign out_data  = main_data_p0;
    assign bp_cnt    = bp_cnt_r;
    assign deliver   = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign bp_event  = (main_vld_p0 & ~out_ready) | stall;

`ifdef PIPE_SKID_EN
    assign in_ready  = ~rst & ~stall & ~skid_vld_p0;
    // The skid register is only ever filled behind a full main register.
    assign occupancy = skid_vld_p0 ? 2'd2 : {1'b0, main_vld_p0};
`else
    assign in_ready  = ~rst & ~stall & (~main_vld_p0 | out_ready);
    assign occupancy = {1'b0, main_vld_p0};
`endif

    // Stage register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p0  <= 1'b0;
            main_data_p0 <= '0;
            bp_cnt_r     <= '0;
`ifdef PIPE_SKID_EN
            skid_vld_p0  <= 1'b0;
            skid_data_p0 <= '0;
`endif
        end else if (flush) begin
            // The backpressure count is left untouched by a flush.
            main_vld_p0 <= 1'b0;
`ifdef PIPE_SKID_EN
            skid_vld_p0 <= 1'b0;
`endif
            if (ZERO_ON_FLUSH) begin
                main_data_p0 <= '0;
`ifdef PIPE_SKID_EN
                skid_data_p0 <= '0;
`endif
            end
        end else if (stall) begin
            bp_cnt_r <= sat_inc(bp_cnt_r);
        end else begin
            if (bp_event) begin
                bp_cnt_r <= sat_inc(bp_cnt_r);
            end
`ifdef PIPE_SKID_EN
            if (deliver) begin
                if (skid_vld_p0) begin
                    // in_ready is low while skid is full.
                    // So no acceptance can collide with this move.
                    main_data_p0 <= skid_data_p0;
                    skid_vld_p0  <= 1'b0;
                end else if (accept) begin
                    main_data_p0 <= in_data;
                end else begin
                    main_vld_p0 <= 1'b0;
                end
            end else if (accept) begin
                if (main_vld_p0) begin
                    skid_data_p0 <= in_data;
                    skid_vld_p0  <= 1'b1;
                end else begin
                    main_data_p0 <= in_data;
                    main_vld_p0  <= 1'b1;
                end
            end
`else
            if (accept) begin
                main_data_p0 <= in_data;
                main_vld_p0  <= 1'b1;
            end else if (deliver) begin
                main_vld_p0 <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg.
// Run the default build, or define PIPE_SKID_EN for the skid-buffer build.
// Inputs change 1 time unit after a rising edge. Outputs are sampled
// 1 unit after the edge, or just before the next edge for
// combinational handshake signals.
module tb_pipe_stage_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [31:0]   bp_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .ZERO_ON_FLUSH(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .bp_cnt    (bp_cnt)
    );

    task automatic set_in(input logic v, input logic [DW-1:0] d, input logic ordy,
                          input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL reset_in_ready cyc%0d: got %b want 0", i, in_ready);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (bp_cnt !== 32'd0) $display("FAIL reset_bp_cnt: got %h want 0", bp_cnt);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, out_data} !== {1'b1, 16'h00A5})
            $display("FAIL post_reset_first_beat: got v=%b d=%h want v=1 d=00a5", out_valid, out_data);
        else pass_cnt++;
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_drain: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_streaming;
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready beat%0d: got %b want 1", k, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({out_valid, out_data} !== {1'b1, DW'(k)})
                $display("FAIL stream_out beat%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, DW'(k));
            else pass_cnt++;
        end
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bp_cnt !== 32'd0) $display("FAIL stream_bp_cnt: got %0d want 0", bp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic [31:0] bp0;
        logic        sent;
        bp0 = bp_cnt;
        set_in(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (occupancy !== 2'd1) $display("FAIL bp_first_occ: got %0d want 1", occupancy);
        else pass_cnt++;
        sent = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            set_in(~sent, 16'h0011, (cyc >= 4), 1'b0, 1'b0);
            #1;
`ifdef PIPE_SKID_EN
            if (cyc == 1) begin
                total_cnt++;
                if (in_ready !== 1'b1) $display("FAIL bp_skid_accept_ready: got %b want 1", in_ready);
                else pass_cnt++;
            end
            if (cyc == 2) begin
                total_cnt++;
                if ({occupancy, in_ready} !== {2'd2, 1'b0})
                    $display("FAIL bp_skid_full: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready);
                else pass_cnt++;
            end
`else
            if (cyc == 1 || cyc == 2) begin
                total_cnt++;
                if ({occupancy, in_ready} !== {2'd1, 1'b0})
                    $display("FAIL bp_full cyc%0d: got occ=%0d rdy=%b want occ=1 rdy=0", cyc, occupancy, in_ready);
                else pass_cnt++;
            end
`endif
            if (cyc == 4) begin
                total_cnt++;
                if ({out_valid, out_data} !== {1'b1, 16'h0010})
                    $display("FAIL bp_deliver_first: got v=%b d=%h want v=1 d=0010", out_valid, out_data);
                else pass_cnt++;
            end
            if (cyc == 5) begin
                total_cnt++;
                if ({out_valid, out_data} !== {1'b1, 16'h0011})
                    $display("FAIL bp_deliver_second: got v=%b d=%h want v=1 d=0011", out_valid, out_data);
                else pass_cnt++;
            end
            if (in_valid && in_ready) sent = 1'b1;
            tick();
        end
        total_cnt++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0})
            $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        else pass_cnt++;
        total_cnt++;
        if (bp_cnt - bp0 !== 32'd3) $display("FAIL bp_count: got %0d want 3", bp_cnt - bp0);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        logic [31:0] bp0;
        set_in(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if ({occupancy, out_data} !== {2'd1, 16'h0055})
            $display("FAIL flush_preload: got occ=%0d d=%h want occ=1 d=0055", occupancy, out_data);
        else pass_cnt++;
        bp0 = bp_cnt;
        set_in(1'b1, 16'h0077, 1'b0, 1'b0, 1'b1);
        tick();
        total_cnt++;
        if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 16'h0000})
            $display("FAIL flush_clear: got v=%b occ=%0d d=%h want v=0 occ=0 d=0000", out_valid, occupancy, out_data);
        else pass_cnt++;
        total_cnt++;
        if (bp_cnt !== bp0) $display("FAIL flush_bp_hold: got %0d want %0d", bp_cnt, bp0);
        else pass_cnt++;
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if ({out_valid, out_data} !== {1'b0, 16'h0000})
                $display("FAIL flush_no_deliver cyc%0d: got v=%b d=%h want v=0 d=0000", i, out_valid, out_data);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_stall_flush;
        logic [31:0] bp0;
        set_in(1'b1, 16'h0099, 1'b1, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if ({occupancy, out_data} !== {2'd1, 16'h0099})
            $display("FAIL stall_preload: got occ=%0d d=%h want occ=1 d=0099", occupancy, out_data);
        else pass_cnt++;
        bp0 = bp_cnt;
        set_in(1'b1, 16'h00EE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++;
            if ({in_ready, out_valid} !== 2'b00)
                $display("FAIL stall_mask cyc%0d: got rdy=%b v=%b want rdy=0 v=0", i, in_ready, out_valid);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({occupancy, out_data} !== {2'd1, 16'h0099})
                $display("FAIL stall_hold cyc%0d: got occ=%0d d=%h want occ=1 d=0099", i, occupancy, out_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (bp_cnt - bp0 !== 32'd2) $display("FAIL stall_bp_count: got %0d want 2", bp_cnt - bp0);
        else pass_cnt++;
        set_in(1'b1, 16'h00EE, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;
        total_cnt++;
        if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 16'h0000})
            $display("FAIL stall_flush_empty: got v=%b occ=%0d d=%h want v=0 occ=0 d=0000", out_valid, occupancy, out_data);
        else pass_cnt++;
        total_cnt++;
        if (bp_cnt - bp0 !== 32'd2) $display("FAIL stall_flush_bp: got %0d want 2", bp_cnt - bp0);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_saturation;
        set_in(1'b1, 16'h003C, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        force dut.bp_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.bp_cnt_r;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (bp_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_bp cyc%0d: got %h want ffffffff", i, bp_cnt);
            else pass_cnt++;
        end
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        total_cnt++;
        if ({bp_cnt, out_valid} !== {32'hFFFF_FFFF, 1'b0})
            $display("FAIL sat_hold: got bp=%h v=%b want bp=ffffffff v=0", bp_cnt, out_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_flush();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
